move_sequencer: RTL

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_if.sv | 31 +++
 rtl/move_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/move_if.sv
// Move sequencer bus: requester handshake, datapath control and response.
// master = sequencer side, slave = requester/datapath side.
interface move_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_source;
    logic [3:0] req_dest;
    logic [3:0] req_offset;
    logic       mc_ready;
    logic [3:0] mc_source;
    logic [3:0] mc_dest;
    logic [3:0] mc_offset;
    logic       mc_move_ready;
    logic       mc_successful;
    logic       resp_valid;
    logic [1:0] resp_status;

    modport master (
        input  req_valid, req_source, req_dest, req_offset,
        input  mc_move_ready, mc_successful,
        output req_ready, mc_ready, mc_source, mc_dest, mc_offset,
        output resp_valid, resp_status
    );

    modport slave (
        output req_valid, req_source, req_dest, req_offset,
        output mc_move_ready, mc_successful,
        input  req_ready, mc_ready, mc_source, mc_dest, mc_offset,
        input  resp_valid, resp_status
    );
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: validates a solitaire move, steps the datapath through
// load/drop/execute phases with per-phase timeout, counts results, flags a win.
module move_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    move_if.master           bus,
    input  logic [27:0]      foundation_cards,
    output logic [CNT_W-1:0] move_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             game_won
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ILL = 2'b01;
    localparam logic [1:0] ST_REJ = 2'b10;
    localparam logic [1:0] ST_TO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD, S_DROP, S_EXEC, S_RESP
    } state_t;

    state_t           r_state;
    logic [3:0]       r_src;
    logic [3:0]       r_dst;
    logic [3:0]       r_off;
    logic [TW-1:0]    r_timer;
    logic             r_mc_ready;
    logic             r_resp_valid;
    logic [1:0]       r_resp_status;
    logic [CNT_W-1:0] r_move_count;
    logic [CNT_W-1:0] r_fail_count;
    logic             r_game_won;

    logic w_all13;
    logic w_legal;
    logic w_timeout;
    logic w_req_ready;

    // Win condition: every foundation slot holds a king (rank 13).
    always_comb begin
        w_all13 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (foundation_cards[i*7+3 +: 4] != 4'd13) begin
                w_all13 = 1'b0;
            end
        end
    end

    assign w_legal     = (r_src <= 4'd8) && ((r_src == 4'd8) || (r_dst <= 4'd7));
    assign w_timeout   = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_req_ready = (r_state == S_IDLE) && !r_game_won;

    assign bus.req_ready   = w_req_ready;
    assign bus.mc_ready    = r_mc_ready;
    assign bus.mc_source   = r_src;
    assign bus.mc_dest     = r_dst;
    assign bus.mc_offset   = r_off;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_status = r_resp_status;
    assign move_count      = r_move_count;
    assign fail_count      = r_fail_count;
    assign game_won        = r_game_won;

    // Sticky win flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_game_won <= 1'b0;
        end else if (w_all13) begin
            r_game_won <= 1'b1;
        end
    end

    // Move FSM with registered datapath request, response and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_src         <= '0;
            r_dst         <= '0;
            r_off         <= '0;
            r_timer       <= '0;
            r_mc_ready    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_status <= ST_OK;
            r_move_count  <= '0;
            r_fail_count  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && w_req_ready) begin
                        r_src   <= bus.req_source;
                        r_dst   <= bus.req_dest;
                        r_off   <= bus.req_offset;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_legal) begin
                        r_mc_ready <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_REJ;
                        r_state       <= S_RESP;
                    end
                end
                S_LOAD, S_DROP, S_EXEC: begin
                    // LOAD/EXEC advance on flag high, DROP on flag low.
                    if ((r_state == S_DROP) ? !bus.mc_move_ready
                                            : bus.mc_move_ready) begin
                        r_timer <= '0;
                        if (r_state == S_LOAD) begin
                            r_state <= S_DROP;
                        end else if (r_state == S_DROP) begin
                            r_state <= S_EXEC;
                        end else begin
                            r_mc_ready    <= 1'b0;
                            r_resp_valid  <= 1'b1;
                            r_resp_status <= bus.mc_successful ? ST_OK : ST_ILL;
                            r_state       <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        r_mc_ready    <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_resp_status <= ST_TO;
                        r_state       <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: begin
                    if (r_resp_status == ST_OK && r_move_count != '1) begin
                        r_move_count <= r_move_count + CNT_W'(1);
                    end
                    if (r_resp_status == ST_ILL && r_fail_count != '1) begin
                        r_fail_count <= r_fail_count + CNT_W'(1);
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mc_ready <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
